// File: rtl/reduce_fn_pkg.sv
// Shared float-unit definitions: reducer state encoding plus the rounding-mode
// and exception-flag layout used by the addFN adder.
package reduce_fn_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FIRST  = 3'd1,
        NEXT   = 3'd2,
        WAIT   = 3'd3,
        FINISH = 3'd4
    } state_e;

    localparam int RM_W   = 3;
    localparam int FLAG_W = 5;

    localparam logic [RM_W-1:0] RM_NEAR_EVEN   = 3'd0;
    localparam logic [RM_W-1:0] RM_MIN_MAG     = 3'd1;
    localparam logic [RM_W-1:0] RM_MIN         = 3'd2;
    localparam logic [RM_W-1:0] RM_MAX         = 3'd3;
    localparam logic [RM_W-1:0] RM_NEAR_MAXMAG = 3'd4;
    localparam logic [RM_W-1:0] RM_ODD         = 3'd6;

    // Flag bit positions: {invalid, infinite, overflow, underflow, inexact}.
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INFINITE  = 3;
    localparam int FLAG_INVALID   = 4;

endpackage

// File: rtl/reduce_fn_if.sv
// Job/operand stream and adder go/done bundle of the sum-reduction controller.
// slave: the reducer; master: the surrounding environment (requester + adder).
interface reduce_fn_if #(
    parameter int expWidth = 8,
    parameter int sigWidth = 24,
    parameter int cntWidth = 16
) ();
    import reduce_fn_pkg::*;

    localparam int W = expWidth + sigWidth;

    logic                go;
    logic [cntWidth-1:0] count;
    logic [RM_W-1:0]     roundingMode;
    logic                in_valid;
    logic [W-1:0]        in_data;
    logic                in_ready;

    logic                add_go;
    logic [W-1:0]        add_left;
    logic [W-1:0]        add_right;
    logic                add_subOp;
    logic [RM_W-1:0]     add_roundingMode;
    logic [W-1:0]        add_out;
    logic [FLAG_W-1:0]   add_exceptionFlags;
    logic                add_done;

    logic [W-1:0]        out;
    logic [FLAG_W-1:0]   exceptionFlags;
    logic                done;

    modport slave (
        input  go, count, roundingMode, in_valid, in_data,
        input  add_out, add_exceptionFlags, add_done,
        output in_ready, add_go, add_left, add_right, add_subOp, add_roundingMode,
        output out, exceptionFlags, done
    );

    modport master (
        output go, count, roundingMode, in_valid, in_data,
        output add_out, add_exceptionFlags, add_done,
        input  in_ready, add_go, add_left, add_right, add_subOp, add_roundingMode,
        input  out, exceptionFlags, done
    );

endinterface

// File: rtl/reduce_fn.sv
// Sequential float sum-reduction: folds `count` streamed operands through one external adder.
// Latency: 2 cycles for count=0, else per operand 1 accept + 1 issue + adder latency, then 2.
// Backpressure: in_ready only in FIRST/NEXT; at most one add outstanding; go ignored unless idle.
module reduce_fn
    import reduce_fn_pkg::*;
#(
    parameter int expWidth = 8,
    parameter int sigWidth = 24,
    parameter int cntWidth = 16
) (
    input  logic       clk,
    input  logic       reset,
    reduce_fn_if.slave io
);

    localparam int W = expWidth + sigWidth;

    state_e              state_q,     state_d;
    logic [cntWidth-1:0] rem_q,       rem_d;
    logic [W-1:0]        acc_q,       acc_d;
    logic [FLAG_W-1:0]   flags_q,     flags_d;
    logic [RM_W-1:0]     rm_q,        rm_d;
    logic                add_go_q,    add_go_d;
    logic [W-1:0]        add_left_q,  add_left_d;
    logic [W-1:0]        add_right_q, add_right_d;
    logic [W-1:0]        out_q,       out_d;
    logic [FLAG_W-1:0]   exc_q,       exc_d;
    logic                done_q,      done_d;
    logic                in_ready;
    logic                last;

    assign last = (rem_q == cntWidth'(1));

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        flags_d     = flags_q;
        rm_d        = rm_q;
        add_go_d    = 1'b0;
        add_left_d  = add_left_q;
        add_right_d = add_right_q;
        out_d       = out_q;
        exc_d       = exc_q;
        done_d      = 1'b0;
        in_ready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The done cycle is already IDLE; a go there belongs to the finished job.
                if (io.go && !done_q) begin
                    rem_d   = io.count;
                    rm_d    = io.roundingMode;
                    flags_d = '0;
                    if (io.count == '0) begin
                        acc_d   = '0;
                        state_d = FINISH;
                    end else begin
                        state_d = FIRST;
                    end
                end
            end
            FIRST: begin
                in_ready = 1'b1;
                if (io.in_valid) begin
                    acc_d   = io.in_data;
                    rem_d   = rem_q - cntWidth'(1);
                    state_d = last ? FINISH : NEXT;
                end
            end
            NEXT: begin
                in_ready = 1'b1;
                if (io.in_valid) begin
                    add_left_d  = acc_q;
                    add_right_d = io.in_data;
                    add_go_d    = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // A done coinciding with our own go cannot be the answer to it.
                if (io.add_done && !add_go_q) begin
                    acc_d   = io.add_out;
                    flags_d = flags_q | io.add_exceptionFlags;
                    rem_d   = rem_q - cntWidth'(1);
                    state_d = last ? FINISH : NEXT;
                end
            end
            FINISH: begin
                out_d   = acc_q;
                exc_d   = flags_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            acc_q       <= '0;
            flags_q     <= '0;
            rm_q        <= '0;
            add_go_q    <= 1'b0;
            add_left_q  <= '0;
            add_right_q <= '0;
            out_q       <= '0;
            exc_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            flags_q     <= flags_d;
            rm_q        <= rm_d;
            add_go_q    <= add_go_d;
            add_left_q  <= add_left_d;
            add_right_q <= add_right_d;
            out_q       <= out_d;
            exc_q       <= exc_d;
            done_q      <= done_d;
        end
    end

    assign io.in_ready         = in_ready;
    assign io.add_go           = add_go_q;
    assign io.add_left         = add_left_q;
    assign io.add_right        = add_right_q;
    assign io.add_subOp        = 1'b0;
    assign io.add_roundingMode = rm_q;
    assign io.out              = out_q;
    assign io.exceptionFlags   = exc_q;
    assign io.done             = done_q;

endmodule
